stack_mem_ctrl: RTL
===================

Name: stack_mem_ctrl

Overview:
- Initiator-side controller for the 128x8 single-port data RAM. That RAM writes and registers its read data on the falling clock edge.
- Turns push/pop/peek/clear commands from the calculator datapath into RAM chip-select, write-enable, address and data cycles.
- Keeps the stack pointer and occupancy count, and returns results with error flags on a response interface.
- Sits between the calculator control FSM and the RAM. It is the only driver of the RAM's cs/we/address/data_in.

Parameters:
- ADDR_W, 7, RAM address width; stack capacity is 2**ADDR_W entries.
- DATA_W, 8, data word width.
- BASE_ADDR, 7'h7F, stack pointer value after reset or clear. The stack grows downward from here.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  00 push, 01 pop, 10 peek, 11 clear.
- cmd_data  input  DATA_W  push operand.
- rsp_valid  output  1  one-cycle pulse; response fields valid.
- rsp_data  output  DATA_W  popped/peeked value, echoed push value, or 0 on error/clear.
- rsp_err  output  1  overflow (push when full) or underflow (pop/peek when empty).
- mem_cs  output  1  RAM chip select.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM registered read data.
- sp  output  ADDR_W  current stack pointer (next free location).
- count  output  ADDR_W+1  entries on stack, 0..2**ADDR_W.
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_W.

Behaviour:
- Reset (synchronous, sampled on the rising edge):
  - state=IDLE, sp=BASE_ADDR, count=0.
  - rsp_valid=0, rsp_err=0, rsp_data=0, data register=0.
  - mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts with no response. RAM contents are not cleared.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready=1. A command is accepted on a rising edge with cmd_valid=1; cmd_op and cmd_data are registered.
  - push && !full -> WRITE.
  - pop/peek && !empty -> READ.
  - push && full, or pop/peek && empty -> RESP with rsp_err=1, rsp_data=0. No RAM access; sp and count unchanged.
  - clear -> sp=BASE_ADDR, count=0, RESP with rsp_err=0, rsp_data=0.
- WRITE (1 cycle):
  - mem_cs=1, mem_we=1, mem_addr=sp, mem_wdata=registered cmd_data.
  - The RAM captures on the falling edge inside this cycle.
  - On exit: sp=sp-1 (mod 2**ADDR_W), count=count+1, rsp_data=pushed value, rsp_err=0 -> RESP.
- READ (1 cycle):
  - mem_cs=1, mem_we=0, mem_addr=sp+1 (mod 2**ADDR_W).
  - The RAM registers its data on the falling edge. On the rising edge ending READ, rsp_data<=mem_rdata and rsp_err<=0.
  - Pop: sp=sp+1, count=count-1. Peek: sp and count unchanged. -> RESP.
- RESP (1 cycle):
  - rsp_valid=1, cmd_ready=0, then -> IDLE.
  - rsp_data and rsp_err hold until the next response. rsp_valid is low in all other states.
- Outside WRITE/READ: mem_cs=0 and mem_we=0. mem_addr and mem_wdata are don't-care but must not toggle when cs=0.
- Latency from accept edge:
  - push/pop/peek: rsp_valid in cycle 2.
  - error/clear: rsp_valid in cycle 1.
- Throughput: one command per 3 cycles (2 for error/clear).
- Wrap-around: pointer arithmetic is modulo 2**ADDR_W. Full/empty are decided by count, never by sp comparison.
- Status outputs: sp, count, empty and full are registered and reflect committed state. They update on the edge leaving WRITE or READ (pop), or on the accept edge for clear.
- cmd_valid while not in IDLE is ignored (cmd_ready=0). No command queuing.

Test Plan:
- Reset, then push 0xA5 -> WRITE cycle shows cs=1, we=1, addr=0x7F, wdata=0xA5. rsp_valid 2 cycles after accept with rsp_data=0xA5, rsp_err=0. sp=0x7E, count=1.
- Push 0x11, 0x22, 0x33, then pop x3 -> rsp_data 0x33, 0x22, 0x11 (LIFO), in that order. Read addresses 0x7D, 0x7E, 0x7F. Final sp=0x7F, count=0, empty=1.
- Pop on empty after reset -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, mem_cs never asserted, sp=0x7F.
- Push 128 values (i=0..127) -> full=1, count=128, sp wraps to 0x7F. Push 0xFF -> rsp_err=1 with no RAM write. Pop -> data 127 from addr 0x00.
- Push 0x5C, peek twice -> both rsp_data=0x5C with count unchanged at 1. Clear -> count=0, sp=0x7F. Peek -> rsp_err=1.
- Assert reset during READ of a pop -> no rsp_valid, sp=0x7F, count=0. Next push writes addr 0x7F. Also check cmd_valid held during RESP is not accepted until IDLE.

Source files
------------

// File: rtl/stack_mem_ctrl.sv
// Stack controller for the 128x8 single-port data RAM: turns push/pop/peek/clear
// commands into RAM cycles and keeps the stack pointer and occupancy count.
module stack_mem_ctrl #(
  parameter int unsigned       ADDR_W    = 7,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 7'h7F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  op_t               cmd_op_e;
  op_t               op_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W:0]   count_q;
  logic              is_full, is_empty, cmd_err;

  assign cmd_op_e = op_t'(cmd_op);
  assign is_full  = (count_q == CAPACITY);
  assign is_empty = (count_q == '0);

  // Full/empty come from the occupancy count only; sp wraps and cannot tell them apart.
  always_comb begin
    cmd_err = 1'b0;
    unique case (cmd_op_e)
      OP_PUSH:         cmd_err = is_full;
      OP_POP, OP_PEEK: cmd_err = is_empty;
      default:         cmd_err = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_err || cmd_op_e == OP_CLEAR) state_nxt = RESP;
          else if (cmd_op_e == OP_PUSH)        state_nxt = WRITE;
          else                                 state_nxt = READ;
        end
      end
      WRITE, READ: state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_cs    = (state == WRITE) || (state == READ);
    mem_we    = (state == WRITE);
  end

  // mem_addr/mem_wdata load only when a RAM cycle follows, so they stay quiet while cs is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q      <= BASE_ADDR;
      count_q   <= '0;
      op_q      <= OP_PUSH;
      data_q    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op_e;
            data_q <= cmd_data;
            if (cmd_err) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end else begin
              unique case (cmd_op_e)
                OP_CLEAR: begin
                  sp_q     <= BASE_ADDR;
                  count_q  <= '0;
                  rsp_err  <= 1'b0;
                  rsp_data <= '0;
                end
                OP_PUSH: begin
                  mem_addr  <= sp_q;
                  mem_wdata <= cmd_data;
                end
                default: mem_addr <= sp_q + ADDR_W'(1);
              endcase
            end
          end
        end
        WRITE: begin
          sp_q     <= sp_q - ADDR_W'(1);
          count_q  <= count_q + (ADDR_W+1)'(1);
          rsp_data <= data_q;
          rsp_err  <= 1'b0;
        end
        READ: begin
          rsp_data <= mem_rdata;
          rsp_err  <= 1'b0;
          if (op_q == OP_POP) begin
            sp_q    <= sp_q + ADDR_W'(1);
            count_q <= count_q - (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sp    = sp_q;
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;

endmodule
